// File: rtl/serial_deser_pkg.sv
// Shared types and helpers for the serial deserializer and its sync front end.
// FSM encoding, default sizing and the even-parity helper live here.
package serial_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_TIMEOUT     = 1024;
  localparam int DEF_SYNC_STAGES = 2;

  // Returns 1 when v holds an odd number of ones (even-parity bit value).
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_deserializer_edge_sync.sv
// Synchronizes sclk/sdata/frame_n through SYNC_STAGES flops and detects the
// synchronized sclk rising edge; reusable by other event-driven counter stages.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic sdata,
  input  logic frame_n,
  output logic rise,
  output logic sdata_s,
  output logic frame_n_s
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] sdata_q;
  logic [SYNC_STAGES-1:0] frame_q;
  logic                   sclk_d;

  // frame_n resets to its inactive level so reset never fakes a frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q  <= '0;
      sdata_q <= '0;
      frame_q <= '1;
      sclk_d  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage capture the previous
      // stage's old value, which is what builds a real multi-flop pipeline.
      sclk_q  <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sdata_q <= {sdata_q[SYNC_STAGES-2:0], sdata};
      frame_q <= {frame_q[SYNC_STAGES-2:0], frame_n};
      sclk_d  <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sdata_s   = sdata_q[SYNC_STAGES-1];
  assign frame_n_s = frame_q[SYNC_STAGES-1];

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver with single-entry output register, overrun,
// abort and timeout flagging. Define SERIAL_DESERIALIZER_PARITY_EN for parity.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             sdata,
  input  logic             frame_n,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             abort_pulse,
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             timeout_pulse
);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  logic rise, sdata_s, frame_n_s;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .sdata     (sdata),
    .frame_n   (frame_n),
    .rise      (rise),
    .sdata_s   (sdata_s),
    .frame_n_s (frame_n_s)
  );

  state_t           state, state_nxt;
  logic [BW-1:0]    bitcnt, bitcnt_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] shift_val, word_val;
  logic             word_done, abort_det, timeout_det;

  assign shift_val = MSB_FIRST ? {shreg[WIDTH-2:0], sdata_s}
                               : {sdata_s, shreg[WIDTH-1:1]};

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  // The data bits are already in shreg when the parity bit arrives.
  logic par_bad;
  assign word_val = shreg;
  assign par_bad  = even_parity(32'(shreg)) ^ sdata_s;
`else
  assign word_val = shift_val;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    state_nxt   = state;
    bitcnt_nxt  = bitcnt;
    tcnt_nxt    = tcnt;
    shreg_nxt   = shreg;
    word_done   = 1'b0;
    abort_det   = 1'b0;
    timeout_det = 1'b0;
    case (state)
      IDLE: begin
        if (!frame_n_s) begin
          state_nxt  = SHIFT;
          bitcnt_nxt = '0;
          tcnt_nxt   = '0;
          shreg_nxt  = '0;
        end
      end
      SHIFT: begin
        if (rise) begin
          tcnt_nxt = '0;
          if (bitcnt < BW'(WIDTH)) shreg_nxt = shift_val;
          if (bitcnt == BW'(NBITS - 1)) begin
            word_done  = 1'b1;
            bitcnt_nxt = '0;
          end else begin
            bitcnt_nxt = bitcnt + 1'b1;
          end
        end else if (bitcnt != '0) begin
          tcnt_nxt = tcnt + 1'b1;
        end
        // A word completing together with frame end is a clean finish.
        if (frame_n_s) begin
          state_nxt = IDLE;
          abort_det = !word_done && (bitcnt != '0);
        end else if (!rise && bitcnt != '0 && tcnt_nxt == TW'(TIMEOUT - 1)) begin
          state_nxt   = IDLE;
          timeout_det = 1'b1;
        end
        if (state_nxt == IDLE) begin
          bitcnt_nxt = '0;
          tcnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift register is reset along with the control state because
  // reset must clear all state, not only the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt <= '0;
      tcnt   <= '0;
      shreg  <= '0;
    end else begin
      bitcnt <= bitcnt_nxt;
      tcnt   <= tcnt_nxt;
      shreg  <= shreg_nxt;
    end
  end

  logic load_word, drop_word;
  assign load_word = word_done && (!out_valid || out_ready);
  assign drop_word = word_done && out_valid && !out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load_word) begin
      out_data  <= word_val;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         parity_err <= 1'b0;
    else if (load_word) parity_err <= par_bad;
  end
`endif

  // A new drop outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun       <= 1'b0;
      abort_pulse   <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      if (drop_word)        overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      abort_pulse   <= abort_det;
      timeout_pulse <= timeout_det;
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench: default, LSB-first and short-timeout instances share one
// serial stream; expected values are hand-computed per scenario.
module tb_serial_deserializer;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset, sclk, sdata, frame_n, out_ready, clr_overrun;

  logic [7:0] d_data, l_data, t_data;
  logic d_valid, l_valid, t_valid;
  logic d_ovr, l_ovr, t_ovr;
  logic d_ab, l_ab, t_ab;
  logic d_tp, l_tp, t_tp;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic d_perr, l_perr, t_perr;
`endif

  always #5 clk = ~clk;

  serial_deserializer dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sdata(sdata), .frame_n(frame_n),
    .out_data(d_data), .out_valid(d_valid), .out_ready(out_ready),
    .overrun(d_ovr), .clr_overrun(clr_overrun), .abort_pulse(d_ab),
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    .parity_err(d_perr),
`endif
    .timeout_pulse(d_tp)
  );

  serial_deserializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .sclk(sclk), .sdata(sdata), .frame_n(frame_n),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .overrun(l_ovr), .clr_overrun(clr_overrun), .abort_pulse(l_ab),
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    .parity_err(l_perr),
`endif
    .timeout_pulse(l_tp)
  );

  serial_deserializer #(.TIMEOUT(16)) dut_to (
    .clk(clk), .reset(reset), .sclk(sclk), .sdata(sdata), .frame_n(frame_n),
    .out_data(t_data), .out_valid(t_valid), .out_ready(out_ready),
    .overrun(t_ovr), .clr_overrun(clr_overrun), .abort_pulse(t_ab),
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    .parity_err(t_perr),
`endif
    .timeout_pulse(t_tp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and negedge monitors.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] d_last = '0, l_last = '0;
  logic d_perr_last = 1'b0;
  int d_cnt = 0, t_cnt = 0, d_vhi = 0, vrise_cyc = 0;
  int d_abn = 0, t_abn = 0, d_tpn = 0, t_tpn = 0, t_tp_cyc = 0;
  logic d_valid_q = 1'b0;
  logic t_state_at_tp = 1'b1;

  always @(negedge clk) begin
    if (d_valid && out_ready) begin
      d_last <= d_data;
      d_cnt  <= d_cnt + 1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      d_perr_last <= d_perr;
`endif
    end
    if (l_valid && out_ready) l_last <= l_data;
    if (t_valid && out_ready) t_cnt  <= t_cnt + 1;
    if (d_valid) d_vhi <= d_vhi + 1;
    if (d_valid && !d_valid_q) vrise_cyc <= cyc;
    d_valid_q <= d_valid;
    if (d_ab) d_abn <= d_abn + 1;
    if (t_ab) t_abn <= t_abn + 1;
    if (d_tp) d_tpn <= d_tpn + 1;
    if (t_tp) begin
      t_tpn         <= t_tpn + 1;
      t_tp_cyc      <= cyc;
      t_state_at_tp <= dut_to.state;
    end
  end

  int last_raise_cyc = 0;

  // Rising sclk every 8 clk: well below the 16-cycle short timeout.
  task automatic send_bit(input logic b);
    @(negedge clk);
    sdata = b;
    sclk  = 1'b0;
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    last_raise_cyc = cyc;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input logic bad_par);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    send_bit((^w) ^ bad_par);
`else
    if (bad_par) send_bit(1'b0);
`endif
  endtask

  task automatic frame_start();
    frame_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    frame_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  int s_cnt, s_vhi, s_ab, s_tab, s_tp, s_ttp, s_tcnt, c0;

  initial begin
    reset = 1'b0; sclk = 1'b0; sdata = 1'b0; frame_n = 1'b1;
    out_ready = 1'b1; clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", d_data, 8'h00);
    check("rst_valid", d_valid, 1'b0);
    check("rst_ovr", d_ovr, 1'b0);
    check("rst_pulses", {d_ab, d_tp}, 2'b00);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // A5 MSB-first: latency and single-cycle valid with out_ready=1.
    s_cnt = d_cnt; s_vhi = d_vhi; s_ab = d_abn; s_tp = d_tpn;
    frame_start();
    send_word(8'hA5, 1'b0);
    check("a5_data", d_last, 8'hA5);
    check("a5_count", d_cnt - s_cnt, 1);
    check("a5_latency", vrise_cyc - last_raise_cyc, SS + 1);
    check("a5_valid_len", d_vhi - s_vhi, 1);
    check("a5_lsb_data", l_last, 8'hA5);
    frame_end();
    check("a5_no_abort", d_abn - s_ab, 0);
    check("a5_no_tmo", d_tpn - s_tp, 0);

    // 01 in MSB-first order: LSB-first instance sees 80.
    frame_start();
    send_word(8'h01, 1'b0);
    check("w01_msb", d_last, 8'h01);
    check("w01_lsb", l_last, 8'h80);
    frame_end();

    // Overrun: two words with out_ready low.
    @(negedge clk);
    out_ready = 1'b0;
    frame_start();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    check("ovr_data", d_data, 8'h11);
    check("ovr_valid", d_valid, 1'b1);
    check("ovr_flag", d_ovr, 1'b1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("ovr_clr", d_ovr, 1'b0);
    frame_end();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_drain", d_valid, 1'b0);
    check("ovr_drain_data", d_last, 8'h11);

    // Abort after 3 bits, then a clean 3C.
    s_ab = d_abn; s_cnt = d_cnt;
    frame_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    frame_end();
    check("abort_len", d_abn - s_ab, 1);
    check("abort_valid", d_valid, 1'b0);
    check("abort_noword", d_cnt - s_cnt, 0);
    frame_start();
    send_word(8'h3C, 1'b0);
    check("after_abort", d_last, 8'h3C);
    frame_end();

    // Timeout on the TIMEOUT=16 instance after 5 bits.
    s_ttp = t_tpn; s_tp = d_tpn; s_tcnt = t_cnt; s_tab = t_abn; s_ab = d_abn;
    frame_start();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    c0 = last_raise_cyc;
    repeat (40) @(negedge clk);
    check("tmo_count", t_tpn - s_ttp, 1);
    // rise seen 2 cycles after the pin; pulse 16 cycles after the rise.
    check("tmo_timing", t_tp_cyc - c0, 18);
    check("tmo_idle", t_state_at_tp, 1'b0);
    check("tmo_noword", t_cnt - s_tcnt, 0);
    check("tmo_default_none", d_tpn - s_tp, 0);
    frame_end();
    check("tmo_no_abort", t_abn - s_tab, 0);
    check("long_to_abort", d_abn - s_ab, 1);

    // Reset mid-word.
    s_ab = d_abn; s_tp = d_tpn;
    frame_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b0;
    #1;
    check("rst_mid_data", d_data, 8'h00);
    check("rst_mid_valid", d_valid, 1'b0);
    check("rst_mid_flags", {d_ovr, d_ab, d_tp}, 3'b000);
    sclk = 1'b0;
    frame_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    frame_start();
    send_word(8'hFF, 1'b0);
    check("post_rst_data", d_last, 8'hFF);
    frame_end();
    check("post_rst_no_pulse", (d_abn - s_ab) + (d_tpn - s_tp), 0);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    s_cnt = d_cnt;
    frame_start();
    send_word(8'h07, 1'b0);
    check("par_good_data", d_last, 8'h07);
    check("par_good_err", d_perr_last, 1'b0);
    send_word(8'h07, 1'b1);
    check("par_bad_data", d_last, 8'h07);
    check("par_bad_err", d_perr_last, 1'b1);
    check("par_words", d_cnt - s_cnt, 2);
    frame_end();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
